// File: rtl/muldiv_ctrl_pkg.sv
// Shared constants and types for the multiply/divide controller.
// Holds op encodings, FSM states, iteration count and the divide-by-zero quotient.
package muldiv_ctrl_pkg;

   localparam logic [1:0] md_mult  = 2'b00;
   localparam logic [1:0] md_multu = 2'b01;
   localparam logic [1:0] md_div   = 2'b10;
   localparam logic [1:0] md_divu  = 2'b11;

   localparam int ITER_COUNT = 32;

   localparam logic [31:0] DIV0_QUOT = 32'hFFFF_FFFF;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_DIV  = 2'd2,
      ST_DONE = 2'd3
   } md_state_t;

endpackage

// File: rtl/muldiv_ctrl_div_iter.sv
// Restoring-divide datapath on unsigned magnitudes; one quotient bit per step.
// Sequencing and sign handling live in muldiv_ctrl.
module muldiv_div_iter #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         resetn,
   input  logic         load_i,
   input  logic         step_i,
   input  logic [W-1:0] dividend_i,
   input  logic [W-1:0] divisor_i,
   output logic [W-1:0] rem_o,
   output logic [W-1:0] quot_o
);

   logic [W-1:0] rem_q, rem_d;
   logic [W-1:0] quot_q, quot_d;
   logic [W:0]   shifted;
   logic [W:0]   diff;

   // Dividend bits shift out of the top of quot_q into the partial remainder.
   always_comb begin
      rem_d   = rem_q;
      quot_d  = quot_q;
      shifted = {rem_q, quot_q[W-1]};
      diff    = shifted - {1'b0, divisor_i};
      if (load_i) begin
         rem_d  = '0;
         quot_d = dividend_i;
      end else if (step_i) begin
         if (!diff[W]) begin
            rem_d  = diff[W-1:0];
            quot_d = {quot_q[W-2:0], 1'b1};
         end else begin
            rem_d  = shifted[W-1:0];
            quot_d = {quot_q[W-2:0], 1'b0};
         end
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         rem_q  <= '0;
         quot_q <= '0;
      end else begin
         rem_q  <= rem_d;
         quot_q <= quot_d;
      end
   end

   assign rem_o  = rem_q;
   assign quot_o = quot_q;

endmodule

// File: rtl/muldiv_ctrl.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer owning architectural HI/LO.
// Define MULDIV_FAST_MUL_EN for a registered single-cycle multiplier instead of shift-add.
module muldiv_ctrl
   import muldiv_ctrl_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            resetn,
   input  logic            start_i,
   input  logic [1:0]      op_i,
   input  logic [XLEN-1:0] src_a_i,
   input  logic [XLEN-1:0] src_b_i,
   input  logic            flush_i,
   input  logic            hilo_we_i,
   input  logic            hilo_sel_i,
   input  logic [XLEN-1:0] hilo_wdata_i,
   output logic            busy_o,
   output logic            done_o,
   output logic [XLEN-1:0] hi_o,
   output logic [XLEN-1:0] lo_o
);

   md_state_t         state_q, state_d;
   logic [4:0]        cnt_q, cnt_d;
   logic              is_div_q, is_div_d;
   logic              neg_res_q, neg_res_d;
   logic              neg_rem_q, neg_rem_d;
   logic              div_zero_q, div_zero_d;
   logic [XLEN-1:0]   a_mag_q, a_mag_d;
   logic [XLEN-1:0]   b_mag_q, b_mag_d;
   logic [XLEN-1:0]   src_a_q, src_a_d;
   logic [XLEN-1:0]   hi_q, hi_d;
   logic [XLEN-1:0]   lo_q, lo_d;
   logic [2*XLEN-1:0] prod_q, prod_d;

   logic              accept;
   logic              is_signed, a_neg, b_neg;
   logic [XLEN-1:0]   a_mag, b_mag;
   logic [XLEN:0]     mul_sum;
   logic [2*XLEN-1:0] prod_fixed;
   logic              div_load, div_step;
   logic [XLEN-1:0]   div_rem, div_quot;

`ifdef MULDIV_FAST_MUL_EN
   logic signed [XLEN:0]     fast_a, fast_b;
   logic signed [2*XLEN-1:0] fast_prod;
   assign fast_a    = {is_signed & src_a_i[XLEN-1], src_a_i};
   assign fast_b    = {is_signed & src_b_i[XLEN-1], src_b_i};
   assign fast_prod = fast_a * fast_b;
`endif

   muldiv_div_iter #(.W(XLEN)) u_div_iter (
      .clk        (clk),
      .resetn     (resetn),
      .load_i     (div_load),
      .step_i     (div_step),
      .dividend_i (a_mag),
      .divisor_i  (b_mag_q),
      .rem_o      (div_rem),
      .quot_o     (div_quot)
   );

   // Signed ops run on magnitudes; the sign fix-up is applied once in DONE.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      is_div_d   = is_div_q;
      neg_res_d  = neg_res_q;
      neg_rem_d  = neg_rem_q;
      div_zero_d = div_zero_q;
      a_mag_d    = a_mag_q;
      b_mag_d    = b_mag_q;
      src_a_d    = src_a_q;
      hi_d       = hi_q;
      lo_d       = lo_q;
      prod_d     = prod_q;
      busy_o     = 1'b0;
      done_o     = 1'b0;
      div_load   = 1'b0;
      div_step   = 1'b0;

      is_signed  = ~op_i[0];
      a_neg      = is_signed & src_a_i[XLEN-1];
      b_neg      = is_signed & src_b_i[XLEN-1];
      a_mag      = a_neg ? -src_a_i : src_a_i;
      b_mag      = b_neg ? -src_b_i : src_b_i;
      accept     = (state_q == ST_IDLE) & start_i & ~flush_i;
      mul_sum    = {1'b0, prod_q[2*XLEN-1:XLEN]} + (prod_q[0] ? {1'b0, a_mag_q} : '0);
      prod_fixed = neg_res_q ? -prod_q : prod_q;

      case (state_q)
         ST_IDLE: begin
            if (hilo_we_i && !flush_i) begin
               if (hilo_sel_i) hi_d = hilo_wdata_i;
               else            lo_d = hilo_wdata_i;
            end
            if (accept) begin
               busy_o     = 1'b1;
               cnt_d      = '0;
               is_div_d   = op_i[1];
               neg_res_d  = a_neg ^ b_neg;
               neg_rem_d  = a_neg;
               div_zero_d = (src_b_i == '0);
               a_mag_d    = a_mag;
               b_mag_d    = b_mag;
               src_a_d    = src_a_i;
               if (op_i[1]) begin
                  div_load = 1'b1;
                  state_d  = ST_DIV;
               end else begin
`ifdef MULDIV_FAST_MUL_EN
                  prod_d    = fast_prod;
                  neg_res_d = 1'b0;
                  state_d   = ST_DONE;
`else
                  prod_d  = {{XLEN{1'b0}}, b_mag};
                  state_d = ST_MUL;
`endif
               end
            end
         end
         ST_MUL: begin
            busy_o = 1'b1;
            prod_d = {mul_sum, prod_q[XLEN-1:1]};
            cnt_d  = cnt_q + 5'd1;
            if (cnt_q == 5'(ITER_COUNT - 1)) state_d = ST_DONE;
         end
         ST_DIV: begin
            busy_o   = 1'b1;
            div_step = 1'b1;
            cnt_d    = cnt_q + 5'd1;
            if (cnt_q == 5'(ITER_COUNT - 1)) state_d = ST_DONE;
         end
         ST_DONE: begin
            done_o  = 1'b1;
            state_d = ST_IDLE;
            if (!is_div_q) begin
               {hi_d, lo_d} = prod_fixed;
            end else if (div_zero_q) begin
               lo_d = DIV0_QUOT;
               hi_d = src_a_q;
            end else begin
               lo_d = neg_res_q ? -div_quot : div_quot;
               hi_d = neg_rem_q ? -div_rem : div_rem;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // A flush cancels the in-flight op outright, including a pending commit.
      if (flush_i) begin
         state_d  = ST_IDLE;
         cnt_d    = '0;
         done_o   = 1'b0;
         div_step = 1'b0;
         if (state_q == ST_DONE) begin
            hi_d = hi_q;
            lo_d = lo_q;
         end
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         is_div_q   <= 1'b0;
         neg_res_q  <= 1'b0;
         neg_rem_q  <= 1'b0;
         div_zero_q <= 1'b0;
         a_mag_q    <= '0;
         b_mag_q    <= '0;
         src_a_q    <= '0;
         hi_q       <= '0;
         lo_q       <= '0;
         prod_q     <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         is_div_q   <= is_div_d;
         neg_res_q  <= neg_res_d;
         neg_rem_q  <= neg_rem_d;
         div_zero_q <= div_zero_d;
         a_mag_q    <= a_mag_d;
         b_mag_q    <= b_mag_d;
         src_a_q    <= src_a_d;
         hi_q       <= hi_d;
         lo_q       <= lo_d;
         prod_q     <= prod_d;
      end
   end

   assign hi_o = hi_q;
   assign lo_o = lo_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Scoreboard bench for muldiv_ctrl: expected HI:LO from an arithmetic model,
// checked by a monitor the cycle after each done_o pulse.
module tb_muldiv_ctrl;

   logic        clk = 1'b0;
   logic        resetn;
   logic        start_i;
   logic [1:0]  op_i;
   logic [31:0] src_a_i, src_b_i;
   logic        flush_i;
   logic        hilo_we_i, hilo_sel_i;
   logic [31:0] hilo_wdata_i;
   logic        busy_o, done_o;
   logic [31:0] hi_o, lo_o;

   int          checks   = 0;
   int          failures = 0;
   logic [63:0] exp_q[$];
   logic [31:0] model_hi, model_lo;

   always #5 clk = ~clk;

   muldiv_ctrl #(.XLEN(32)) dut (
      .clk          (clk),
      .resetn       (resetn),
      .start_i      (start_i),
      .op_i         (op_i),
      .src_a_i      (src_a_i),
      .src_b_i      (src_b_i),
      .flush_i      (flush_i),
      .hilo_we_i    (hilo_we_i),
      .hilo_sel_i   (hilo_sel_i),
      .hilo_wdata_i (hilo_wdata_i),
      .busy_o       (busy_o),
      .done_o       (done_o),
      .hi_o         (hi_o),
      .lo_o         (lo_o)
   );

   task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
      end
   endtask

   // Architectural result straight from integer arithmetic on the operands.
   function automatic logic [63:0] ref_model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      longint          sa, sb, q, r;
      longint unsigned ua, ub;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = {32'b0, a};
      ub = {32'b0, b};
      case (op)
         2'b00: return sa * sb;
         2'b01: return ua * ub;
         2'b10: begin
            if (b == 32'h0) return {a, 32'hFFFF_FFFF};
            q = sa / sb;
            r = sa % sb;
            return {r[31:0], q[31:0]};
         end
         default: begin
            if (b == 32'h0) return {a, 32'hFFFF_FFFF};
            return {32'(ua % ub), 32'(ua / ub)};
         end
      endcase
   endfunction

   function automatic int expected_busy(input logic [1:0] op);
`ifdef MULDIV_FAST_MUL_EN
      if (!op[1]) return 1;
`endif
      return 33;
   endfunction

   // Issues one op, counts busy cycles, optionally tries an MTHI mid-operation.
   task automatic apply_stimulus(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input bit mt_during);
      int          nbusy;
      logic [63:0] exp;
      exp = ref_model(op, a, b);
      @(posedge clk); #1;
      start_i = 1'b1; op_i = op; src_a_i = a; src_b_i = b;
      exp_q.push_back(exp);
      @(negedge clk);
      nbusy = busy_o ? 1 : 0;
      @(posedge clk); #1;
      start_i = 1'b0;
      for (int c = 0; c < 100; c++) begin
         @(negedge clk);
         hilo_we_i = 1'b0;
         if (!busy_o) break;
         nbusy++;
         if (mt_during && nbusy == 6) begin
            hilo_we_i = 1'b1; hilo_sel_i = 1'b1; hilo_wdata_i = 32'hDEAD_BEEF;
         end
         if (mt_during && nbusy == 7)
            check_output("mt_ignored_busy", {32'h0, hi_o}, {32'h0, model_hi});
      end
      check_output($sformatf("busy_cycles_op%0d", op), 64'(nbusy), 64'(expected_busy(op)));
      check_output("done_in_done_cycle", {63'h0, done_o}, 64'h1);
      model_hi = exp[63:32];
      model_lo = exp[31:0];
   endtask

   task automatic mt_write(input logic sel, input logic [31:0] data);
      @(posedge clk); #1;
      hilo_we_i = 1'b1; hilo_sel_i = sel; hilo_wdata_i = data;
      @(posedge clk); #1;
      hilo_we_i = 1'b0;
      if (sel) model_hi = data; else model_lo = data;
      @(negedge clk);
      check_output(sel ? "mthi" : "mtlo", {hi_o, lo_o}, {model_hi, model_lo});
   endtask

   // Monitor: every done pulse must match the oldest outstanding expectation.
   initial begin
      logic [63:0] exp;
      forever begin
         @(negedge clk);
         if (done_o) begin
            if (exp_q.size() == 0) begin
               check_output("unexpected_done", 64'h1, 64'h0);
            end else begin
               exp = exp_q.pop_front();
               @(negedge clk);
               check_output("hilo_result", {hi_o, lo_o}, exp);
            end
         end
      end
   end

   initial begin
      resetn = 1'b0; start_i = 1'b0; op_i = 2'b00; src_a_i = '0; src_b_i = '0;
      flush_i = 1'b0; hilo_we_i = 1'b0; hilo_sel_i = 1'b0; hilo_wdata_i = '0;
      model_hi = '0; model_lo = '0;
      #12;
      check_output("reset_outputs", {busy_o, done_o, hi_o, lo_o}, 66'h0);
      @(negedge clk);
      resetn = 1'b1;

      apply_stimulus(2'b00, 32'hFFFF_FFFF, 32'h2, 1'b0);
      apply_stimulus(2'b01, 32'hFFFF_FFFF, 32'h2, 1'b0);
      apply_stimulus(2'b10, 32'hFFFF_FFF9, 32'h2, 1'b0);
      apply_stimulus(2'b11, 32'h7, 32'h2, 1'b0);
      apply_stimulus(2'b11, 32'h1234_5678, 32'h0, 1'b0);
      apply_stimulus(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
      apply_stimulus(2'b10, 32'hF000_0001, 32'h0, 1'b0);

      mt_write(1'b1, 32'hA5A5_A5A5);
      mt_write(1'b0, 32'h5A5A_0F0F);
      apply_stimulus(2'b11, 32'h0000_1000, 32'h3, 1'b1);

      // Flush in cycle 10 of a DIV: no commit, then a fresh DIV right after.
      @(posedge clk); #1;
      start_i = 1'b1; op_i = 2'b10; src_a_i = 32'h1111_2222; src_b_i = 32'h7;
      @(posedge clk); #1;
      start_i = 1'b0;
      repeat (9) @(posedge clk);
      #1 flush_i = 1'b1;
      @(posedge clk); #1;
      flush_i = 1'b0;
      @(negedge clk);
      check_output("busy_after_flush", {63'h0, busy_o}, 64'h0);
      repeat (30) @(negedge clk);
      check_output("hilo_after_flush", {hi_o, lo_o}, {model_hi, model_lo});
      apply_stimulus(2'b10, 32'hFFFF_FF00, 32'h0000_0013, 1'b0);

      // Asynchronous reset in cycle 20 of a MULTU.
      @(posedge clk); #1;
      start_i = 1'b1; op_i = 2'b01; src_a_i = 32'hCAFE_F00D; src_b_i = 32'h1234_5678;
      @(posedge clk); #1;
      start_i = 1'b0;
      repeat (19) @(posedge clk);
      #3 resetn = 1'b0;
      #1;
      check_output("async_reset_outputs", {busy_o, done_o, hi_o, lo_o}, 66'h0);
      model_hi = '0; model_lo = '0;
      @(negedge clk);
      @(negedge clk);
      resetn = 1'b1;
      apply_stimulus(2'b00, 32'h8000_0001, 32'h7FFF_FFFF, 1'b0);

      for (int i = 0; i < 16; i++) begin
         logic [1:0]  rop;
         logic [31:0] ra, rb;
         rop = 2'($urandom_range(0, 3));
         ra  = $urandom;
         rb  = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
         if ($urandom_range(0, 3) == 0) rb = rb >> $urandom_range(16, 31);
         apply_stimulus(rop, ra, rb, 1'b0);
      end

      repeat (4) @(negedge clk);
      check_output("scoreboard_drained", 64'(exp_q.size()), 64'h0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
